// File: rtl/seq_div.sv
// seq_div: iterative signed divider (radix-2 restoring, one quotient bit per cycle)
// with valid/ready handshakes on both sides. Quotient truncates toward zero and
// the remainder takes the sign of the dividend; divide by zero is flagged.
module seq_div #(
  parameter int unsigned DWI = 8,
  parameter int unsigned DWO = 16
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [DWO-1:0] dividend,
  input  logic [DWI-1:0] divisor,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [DWO-1:0] quotient,
  output logic [DWI-1:0] remainder,
  output logic           out_dbz
);

  localparam int unsigned CW = (DWO > 1) ? $clog2(DWO) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_FIX  = 2'd2,
    S_DONE = 2'd3
  } state_e;

  state_e         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [DWI:0]   prem_q, prem_d;          // partial remainder
  logic [DWO-1:0] dvd_q, dvd_d;            // dividend bits shift out, quotient bits shift in
  logic [DWI-1:0] dvs_q, dvs_d;            // |divisor|
  logic           neg_quo_q, neg_quo_d;
  logic           neg_rem_q, neg_rem_d;
  logic [DWO-1:0] quot_q, quot_d;
  logic [DWI-1:0] rmd_q, rmd_d;
  logic           dbz_q, dbz_d;
  logic           in_ready_q, in_ready_d;
  logic           out_valid_q, out_valid_d;

  logic           accept_c;
  logic           last_c;
  logic [DWO-1:0] dvd_mag_c;
  logic [DWI-1:0] dvs_mag_c;
  logic [DWI:0]   shift_c;
  logic [DWI:0]   diff_c;
  logic           borrow_c;
  logic           unused_prem_msb;

  assign accept_c  = (state_q == S_IDLE) && in_valid;
  assign last_c    = (cnt_q == CW'(DWO - 1));
  assign dvd_mag_c = dividend[DWO-1] ? -dividend : dividend;
  assign dvs_mag_c = divisor[DWI-1]  ? -divisor  : divisor;

  // One restoring step: bring in the next dividend bit and trial-subtract |divisor|
  assign shift_c             = {prem_q[DWI-1:0], dvd_q[DWO-1]};
  assign {borrow_c, diff_c}  = {1'b0, shift_c} - {2'b00, dvs_q};

  // Partial remainder stays below |divisor| <= 2^(DWI-1), so its top bit is always zero
  assign unused_prem_msb = prem_q[DWI];

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          state_d = (divisor == '0) ? S_DONE : S_CALC;
        end
      end
      S_CALC: begin
        if (last_c) begin
          state_d = S_FIX;
        end
      end
      S_FIX:  state_d = S_DONE;
      S_DONE: begin
        if (out_ready) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output and datapath next values
  always_comb begin
    cnt_d       = cnt_q;
    prem_d      = prem_q;
    dvd_d       = dvd_q;
    dvs_d       = dvs_q;
    neg_quo_d   = neg_quo_q;
    neg_rem_d   = neg_rem_q;
    quot_d      = quot_q;
    rmd_d       = rmd_q;
    dbz_d       = dbz_q;
    in_ready_d  = (state_d == S_IDLE);
    out_valid_d = (state_d == S_DONE);
    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          neg_quo_d = dividend[DWO-1] ^ divisor[DWI-1];
          neg_rem_d = dividend[DWO-1];
          dvd_d     = dvd_mag_c;
          dvs_d     = dvs_mag_c;
          cnt_d     = '0;
          prem_d    = '0;
          dbz_d     = (divisor == '0);
          if (divisor == '0) begin
            quot_d = '1;
            rmd_d  = dividend[DWI-1:0];
          end
        end
      end
      S_CALC: begin
        prem_d = borrow_c ? shift_c : diff_c;
        dvd_d  = {dvd_q[DWO-2:0], ~borrow_c};
        cnt_d  = cnt_q + CW'(1);
      end
      S_FIX: begin
        quot_d = neg_quo_q ? -dvd_q : dvd_q;
        rmd_d  = neg_rem_q ? -prem_q[DWI-1:0] : prem_q[DWI-1:0];
      end
      default: ;
    endcase
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      prem_q      <= '0;
      dvd_q       <= '0;
      dvs_q       <= '0;
      neg_quo_q   <= 1'b0;
      neg_rem_q   <= 1'b0;
      quot_q      <= '0;
      rmd_q       <= '0;
      dbz_q       <= 1'b0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      cnt_q       <= cnt_d;
      prem_q      <= prem_d;
      dvd_q       <= dvd_d;
      dvs_q       <= dvs_d;
      neg_quo_q   <= neg_quo_d;
      neg_rem_q   <= neg_rem_d;
      quot_q      <= quot_d;
      rmd_q       <= rmd_d;
      dbz_q       <= dbz_d;
      in_ready_q  <= in_ready_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign quotient  = quot_q;
  assign remainder = rmd_q;
  assign out_dbz   = dbz_q;

endmodule
